// File: rtl/sw_pkg.sv
// Shared definitions for the SW_core stream loader: lengths, header layout, states.
// Word counts derive from the max lengths; the checksum state is used only with SW_LOADER_CHKSUM_EN.
package sw_pkg;

    localparam int SW_REF_MAX_LEN  = 128;
    localparam int SW_READ_MAX_LEN = 128;
    localparam int SW_WORD_W       = 32;

    localparam int SW_REF_LEN_W  = $clog2(SW_REF_MAX_LEN) + 1;
    localparam int SW_READ_LEN_W = $clog2(SW_READ_MAX_LEN) + 1;

    localparam int HDR_FIELD_W  = 16;
    localparam int HDR_REF_LSB  = 16;
    localparam int HDR_READ_LSB = 0;

    function automatic int words_of(input int max_len, input int word_w);
        return (2 * max_len) / word_w;
    endfunction

    localparam int REF_WORDS  = words_of(SW_REF_MAX_LEN, SW_WORD_W);
    localparam int READ_WORDS = words_of(SW_READ_MAX_LEN, SW_WORD_W);

    typedef logic [2:0] state_t;

    localparam state_t S_HDR   = 3'd0;
    localparam state_t S_REF   = 3'd1;
    localparam state_t S_READ  = 3'd2;
    localparam state_t S_CHK   = 3'd3;
    localparam state_t S_ISSUE = 3'd4;

endpackage

// File: rtl/sw_word_shifter.sv
// Shift-in register: each load moves contents up one word and inserts din at the LSBs,
// so the first word loaded ends up in the MSBs once the register is full.
module sw_word_shifter #(
    parameter int W      = 256,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic [W-1:0]      q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = {q_q[W-WORD_W-1:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sw_seq_loader.sv
// Assembles header/ref/read stream packets and issues them to SW_core with a one-cycle valid.
// SW_LOADER_CHKSUM_EN adds a trailing XOR checksum word checked in S_CHK.
module sw_seq_loader
    import sw_pkg::*;
#(
    parameter int REF_MAX_LEN  = SW_REF_MAX_LEN,
    parameter int READ_MAX_LEN = SW_READ_MAX_LEN,
    parameter int WORD_W       = SW_WORD_W,
    localparam int RLW = $clog2(REF_MAX_LEN) + 1,
    localparam int DLW = $clog2(READ_MAX_LEN) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WORD_W-1:0]         s_data,
    input  logic                      sw_ready,
    output logic                      sw_valid,
    output logic [2*REF_MAX_LEN-1:0]  sw_seq_ref,
    output logic [2*READ_MAX_LEN-1:0] sw_seq_read,
    output logic [RLW-1:0]            sw_ref_len,
    output logic [DLW-1:0]            sw_read_len,
    output logic                      o_busy,
    output logic                      o_err,
    output logic [15:0]               o_pkt_cnt
);

    localparam int N_REF  = words_of(REF_MAX_LEN, WORD_W);
    localparam int N_READ = words_of(READ_MAX_LEN, WORD_W);
    localparam int N_MAX  = (N_REF > N_READ) ? N_REF : N_READ;
    localparam int CNT_W  = $clog2(N_MAX + 1);

    localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(N_REF - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(N_READ - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             len_bad_q, len_bad_d;
    logic [RLW-1:0]   ref_len_q, ref_len_d;
    logic [DLW-1:0]   read_len_q, read_len_d;
    logic             sw_valid_q, sw_valid_d;
    logic             err_q, err_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic                   xfer;
    logic                   clr;
    logic                   ref_ld;
    logic                   read_ld;
    logic [HDR_FIELD_W-1:0] ref_f;
    logic [HDR_FIELD_W-1:0] read_f;
    logic                   hdr_bad;

    assign xfer   = s_valid & s_ready;
    assign ref_f  = s_data[HDR_REF_LSB +: HDR_FIELD_W];
    assign read_f = s_data[HDR_READ_LSB +: HDR_FIELD_W];

    assign hdr_bad = (ref_f == '0) || (ref_f > HDR_FIELD_W'(REF_MAX_LEN))
                  || (read_f == '0) || (read_f > HDR_FIELD_W'(READ_MAX_LEN));

`ifdef SW_LOADER_CHKSUM_EN
    logic [WORD_W-1:0] chk_q, chk_d;

    // Running XOR restarts at the header so it covers every word of this packet.
    always_comb begin
        chk_d = chk_q;
        if (xfer) begin
            if (state_q == S_HDR) begin
                chk_d = s_data;
            end else if (state_q == S_REF || state_q == S_READ) begin
                chk_d = chk_q ^ s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_bad_d  = len_bad_q;
        ref_len_d  = ref_len_q;
        read_len_d = read_len_q;
        pkt_cnt_d  = pkt_cnt_q;
        sw_valid_d = 1'b0;
        err_d      = 1'b0;
        clr        = 1'b0;
        ref_ld     = 1'b0;
        read_ld    = 1'b0;
        unique case (state_q)
            S_HDR: begin
                if (xfer) begin
                    ref_len_d  = ref_f[RLW-1:0];
                    read_len_d = read_f[DLW-1:0];
                    len_bad_d  = hdr_bad;
                    clr        = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_REF;
                end
            end
            S_REF: begin
                if (xfer) begin
                    ref_ld = 1'b1;
                    if (cnt_q == REF_LAST) begin
                        cnt_d   = '0;
                        state_d = S_READ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_READ: begin
                if (xfer) begin
                    read_ld = 1'b1;
                    if (cnt_q == READ_LAST) begin
                        cnt_d = '0;
`ifdef SW_LOADER_CHKSUM_EN
                        state_d = S_CHK;
`else
                        err_d   = len_bad_q;
                        state_d = len_bad_q ? S_HDR : S_ISSUE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SW_LOADER_CHKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    err_d   = len_bad_q || (s_data != chk_q);
                    state_d = err_d ? S_HDR : S_ISSUE;
                end
            end
`endif
            S_ISSUE: begin
                if (sw_ready) begin
                    sw_valid_d = 1'b1;
                    pkt_cnt_d  = pkt_cnt_q + 16'd1;
                    state_d    = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HDR;
            cnt_q      <= '0;
            len_bad_q  <= 1'b0;
            ref_len_q  <= '0;
            read_len_q <= '0;
            sw_valid_q <= 1'b0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_bad_q  <= len_bad_d;
            ref_len_q  <= ref_len_d;
            read_len_q <= read_len_d;
            sw_valid_q <= sw_valid_d;
            err_q      <= err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    sw_word_shifter #(.W(2*REF_MAX_LEN), .WORD_W(WORD_W)) u_ref_sh (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (ref_ld),
        .din   (s_data),
        .q     (sw_seq_ref)
    );

    sw_word_shifter #(.W(2*READ_MAX_LEN), .WORD_W(WORD_W)) u_read_sh (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (read_ld),
        .din   (s_data),
        .q     (sw_seq_read)
    );

    assign s_ready     = (state_q != S_ISSUE);
    assign o_busy      = (state_q != S_HDR);
    assign sw_valid    = sw_valid_q;
    assign o_err       = err_q;
    assign o_pkt_cnt   = pkt_cnt_q;
    assign sw_ref_len  = ref_len_q;
    assign sw_read_len = read_len_q;

endmodule
